interrupt_controller: RTL
=========================

// Module: interrupt_controller
// PURPOSE
//  Holds the interrupt flag (IF, 0xFF0F) and interrupt enable (IE, 0xFFFF) registers and sits directly upstream of the CPU.
//  It turns peripheral request edges into latched IF bits and drives the CPU's 5-bit pending-interrupt input (IF & IE).
//  It consumes the CPU's handle-interrupt strobe: it clears the serviced IF bit and supplies the vector address.
//  It is memory-mapped on the CPU address/data bus, and its read data is ORed onto the 8-bit return bus.
// PARAMETERS
//  NUM_IRQ      5         number of interrupt sources; bit 0 has highest priority
//  IF_ADDR      16'hFF0F  address of IF register
//  IE_ADDR      16'hFFFF  address of IE register
//  VECTOR_BASE  16'h0040  vector of source 0; source n vector = VECTOR_BASE + 8*n
// PORTS
//  i_Clk               in   1   system clock
//  i_Rst               in   1   asynchronous reset, active-high
//  i_Enable            in   1   clock enable; no state changes while low
//  i_Address           in   16  CPU address
//  i_Bus               in   8   CPU write data
//  i_Write             in   1   CPU write strobe, valid with i_Address
//  i_Read              in   1   CPU read strobe, valid with i_Address
//  o_Bus               out  8   read data; 8'h00 unless reading IF/IE
//  i_Requests          in   5   peripheral request levels (VBlank, STAT, Timer, Serial, Joypad)
//  i_Handle_Interrupt  in   1   CPU is entering interrupt service
//  o_Interrupts        out  5   IF & IE[4:0], to CPU i_Interrupts
//  o_Vector            out  16  vector of the last acknowledged source
//  o_Ack_Valid         out  1   one-cycle pulse: acknowledge taken, o_Vector updated
// BEHAVIOUR
//  Clock and reset
//  - Single clock domain, i_Clk. Reset is asynchronous and active-high on i_Rst.
//  - Reset values: IF=0, IE=0, req_q=0, hi_q=0, o_Vector=0, o_Ack_Valid=0. Therefore o_Interrupts=0 and o_Bus=0.
//  - Reset mid-operation wipes pending and in-flight acknowledges immediately.
//  - All registers update only on rising i_Clk with i_Enable=1. With i_Enable=0, state holds and o_Ack_Valid is forced 0.
//  Edge detect
//  - req_q <= i_Requests each enabled cycle.
//  - rise = i_Requests & ~req_q.
//  - A level held high sets IF only once.
//  Acknowledge
//  - hi_q <= i_Handle_Interrupt.
//  - ack = i_Handle_Interrupt & ~hi_q & (o_Interrupts != 0).
//  - On ack: sel = index of the lowest set bit of o_Interrupts, and ack_mask = 1<<sel.
//  - o_Vector <= VECTOR_BASE + {sel,3'b000} and o_Ack_Valid <= 1 for one cycle.
//  - An ack with o_Interrupts=0 does nothing (no pulse, o_Vector held).
//  IF update (one enabled cycle)
//  - base = (i_Write && i_Address==IF_ADDR) ? i_Bus[4:0] : IF.
//  - IF_next = (base & ~ack_mask) | rise.
//  - Priority: a new rise wins over both the ack clear and a CPU write of 0. A CPU write overrides the old IF.
//  IE
//  - IE is 8-bit and is written when i_Write && i_Address==IE_ADDR. Only IE[4:0] gates o_Interrupts.
//  Outputs and timing
//  - o_Interrupts is combinational from the registers.
//  - Latency: request edge sampled on clock k shows on o_Interrupts after clock k.
//  - A written IF/IE value is visible after the writing clock.
//  Read data (combinational, 0-cycle)
//  - IF read returns {3'b111, IF}.
//  - IE read returns IE[7:0].
//  - Any other address, or i_Read=0, returns 8'h00.
//  - Read and write in the same cycle: read returns the old value.
// TESTING
//  1. Assert i_Rst mid-run with IF=1F -> IF=0, o_Interrupts=0, o_Bus=0 asynchronously; after release, a read of FF0F returns E0.
//  2. IE=05, hold i_Requests=00001 for 10 cycles, ack once -> o_Interrupts=01 then 00 after ack; no re-set while the level stays high.
//  3. IE=1F, IF=14, pulse i_Handle_Interrupt -> o_Vector=0050 with o_Ack_Valid high for 1 cycle, IF=10. Second ack -> o_Vector=0060, IF=00.
//  4. Same cycle: write FF0F=00, rise on bit 2, ack of bit 0 with IF=01 -> IF=04.
//  5. i_Enable=0 with a request edge and a write to FFFF=FF -> IF/IE unchanged. The edge is still seen once i_Enable=1 if the level is held.
//  6. Write FFFF=A3, read FFFF -> A3; o_Interrupts = IF & 03.

Source files
------------

// File: rtl/interrupt_controller.sv
// Interrupt flag/enable registers, request edge latching and
// priority acknowledge with vector generation for the CPU.
module interrupt_controller #(
   parameter int          NUM_IRQ     = 5,
   parameter logic [15:0] IF_ADDR     = 16'hFF0F,
   parameter logic [15:0] IE_ADDR     = 16'hFFFF,
   parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic               i_Enable,
   input  logic [15:0]        i_Address,
   input  logic [7:0]         i_Bus,
   input  logic               i_Write,
   input  logic               i_Read,
   output logic [7:0]         o_Bus,
   input  logic [NUM_IRQ-1:0] i_Requests,
   input  logic               i_Handle_Interrupt,
   output logic [NUM_IRQ-1:0] o_Interrupts,
   output logic [15:0]        o_Vector,
   output logic               o_Ack_Valid
);

   localparam int SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   logic [NUM_IRQ-1:0] if_q;
   logic [7:0]         ie_q;
   logic [NUM_IRQ-1:0] req_q;
   logic               hi_q;

   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] if_base;
   logic [NUM_IRQ-1:0] if_next;
   logic [NUM_IRQ-1:0] ack_mask;
   logic [SEL_W-1:0]   sel;
   logic [15:0]        vec_next;
   logic               ack;
   logic               wr_if;
   logic               wr_ie;

   assign o_Interrupts = if_q & ie_q[NUM_IRQ-1:0];
   assign rise         = i_Requests & ~req_q;
   assign ack          = i_Handle_Interrupt & ~hi_q & (|o_Interrupts);
   assign wr_if        = i_Write && (i_Address == IF_ADDR);
   assign wr_ie        = i_Write && (i_Address == IE_ADDR);

   // descending scan so the lowest pending index wins
   always_comb begin
      sel = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (o_Interrupts[i]) sel = SEL_W'(i);
      end
   end

   always_comb begin
      ack_mask = '0;
      if (ack) ack_mask = NUM_IRQ'(1) << sel;
   end

   assign vec_next = VECTOR_BASE + 16'({sel, 3'b000});
   assign if_base  = wr_if ? i_Bus[NUM_IRQ-1:0] : if_q;
   assign if_next  = (if_base & ~ack_mask) | rise;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         if_q        <= '0;
         ie_q        <= '0;
         req_q       <= '0;
         hi_q        <= 1'b0;
         o_Vector    <= '0;
         o_Ack_Valid <= 1'b0;
      end else if (i_Enable) begin
         if_q        <= if_next;
         req_q       <= i_Requests;
         hi_q        <= i_Handle_Interrupt;
         o_Ack_Valid <= ack;
         if (wr_ie) ie_q <= i_Bus;
         if (ack) o_Vector <= vec_next;
      end else begin
         o_Ack_Valid <= 1'b0;
      end
   end

   always_comb begin
      o_Bus = 8'h00;
      if (i_Read && (i_Address == IF_ADDR))
         o_Bus = {{(8 - NUM_IRQ){1'b1}}, if_q};
      else if (i_Read && (i_Address == IE_ADDR))
         o_Bus = ie_q;
   end

endmodule
